// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand request channel in, result channel out.
// master = producer/consumer side, slave = the adder.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first, one carry register.
// IDLE accepts operands, RUN takes WIDTH/DIGIT cycles, DONE holds the result until taken.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] sum_shift;

    // Subtraction is A + ~B + ~cin, so B is inverted once at accept time.
    assign b_eff = bus.b ^ {WIDTH{bus.sub}};

    assign digit_sum = {1'b0, a_sh_q[DIGIT-1:0]}
                     + {1'b0, b_sh_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};

    // New digit enters the result from the MSB end; a single digit fills it outright.
    generate
        if (DIGIT == WIDTH) begin : g_full_digit
            assign sum_shift = digit_sum[DIGIT-1:0];
        end else begin : g_part_digit
            assign sum_shift = {digit_sum[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = b_eff;
                    carry_d  = bus.cin ^ bus.sub;
                    a_sign_d = bus.a[WIDTH-1];
                    b_sign_d = b_eff[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                sum_d   = sum_shift;
                carry_d = digit_sum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cout_d  = digit_sum[DIGIT];
                    ovf_d   = (a_sign_q == b_sign_q) && (sum_shift[WIDTH-1] != a_sign_q);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: DIGIT=4 main instance plus DIGIT=1 and DIGIT=16
// instances driven in lock-step against a signed/unsigned reference.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_sw_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(16)) if_m ();
    serial_adder_if #(.WIDTH(16)) if_d1 ();
    serial_adder_if #(.WIDTH(16)) if_d16 ();

    serial_adder #(.WIDTH(16), .DIGIT(4))  u_main (.clk(clk), .rst_n(rst_n),    .bus(if_m));
    serial_adder #(.WIDTH(16), .DIGIT(1))  u_d1   (.clk(clk), .rst_n(rst_sw_n), .bus(if_d1));
    serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16  (.clk(clk), .rst_n(rst_sw_n), .bus(if_d16));

    logic        sw_in_valid, sw_out_ready, sw_cin, sw_sub;
    logic [15:0] sw_a, sw_b;

    assign if_d1.in_valid   = sw_in_valid;
    assign if_d1.out_ready  = sw_out_ready;
    assign if_d1.a          = sw_a;
    assign if_d1.b          = sw_b;
    assign if_d1.cin        = sw_cin;
    assign if_d1.sub        = sw_sub;
    assign if_d16.in_valid  = sw_in_valid;
    assign if_d16.out_ready = sw_out_ready;
    assign if_d16.a         = sw_a;
    assign if_d16.b         = sw_b;
    assign if_d16.cin       = sw_cin;
    assign if_d16.sub       = sw_sub;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_main(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (if_m.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pop_main(input string tag);
        if_m.out_ready = 1'b1;
        @(posedge clk); #1;
        if_m.out_ready = 1'b0;
        chk({tag, "_popped"}, 32'(if_m.out_valid), 32'd0);
        chk({tag, "_idle"},   32'(if_m.in_ready),  32'd1);
    endtask

    task automatic txn_main(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic ci, input logic sb, input logic [15:0] es,
                            input logic ec, input logic eo);
        int lat;
        chk({tag, "_rdy"}, 32'(if_m.in_ready), 32'd1);
        if_m.a = av; if_m.b = bv; if_m.cin = ci; if_m.sub = sb;
        if_m.in_valid = 1'b1;
        @(posedge clk); #1;
        if_m.in_valid = 1'b0;
        if_m.a = 16'hDEAD; if_m.b = 16'hBEEF;
        wait_main(lat);
        chk({tag, "_lat"},  32'(lat),         32'd4);
        chk({tag, "_sum"},  32'(if_m.sum),    32'(es));
        chk({tag, "_cout"}, 32'(if_m.cout),   32'(ec));
        chk({tag, "_ovf"},  32'(if_m.ovf),    32'(eo));
        pop_main(tag);
    endtask

    initial begin
        int          lat, lat1, lat16;
        int          sa, sb, ua, ub, ru, rs;
        logic [15:0] e_sum;
        logic        e_cout, e_ovf;
        logic [31:0] ru_bits;

        rst_n = 1'b0; rst_sw_n = 1'b0;
        if_m.in_valid = 1'b0; if_m.out_ready = 1'b0;
        if_m.a = '0; if_m.b = '0; if_m.cin = 1'b0; if_m.sub = 1'b0;
        sw_in_valid = 1'b0; sw_out_ready = 1'b0;
        sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        #2;
        chk("rst_in_ready",  32'(if_m.in_ready),  32'd1);
        chk("rst_out_valid", 32'(if_m.out_valid), 32'd0);
        chk("rst_sum",       32'(if_m.sum),       32'd0);
        chk("rst_cout",      32'(if_m.cout),      32'd0);
        chk("rst_ovf",       32'(if_m.ovf),       32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; rst_sw_n = 1'b1;

        txn_main("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        txn_main("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        txn_main("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        txn_main("add_cin",   16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        txn_main("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        txn_main("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        txn_main("sub_cin",   16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

        // Backpressure with pending operands held on the input.
        if_m.a = 16'h1111; if_m.b = 16'h2222; if_m.cin = 1'b0; if_m.sub = 1'b0;
        if_m.in_valid = 1'b1;
        @(posedge clk); #1;
        if_m.in_valid = 1'b0;
        wait_main(lat);
        chk("bp_lat", 32'(lat), 32'd4);
        if_m.a = 16'h0100; if_m.b = 16'h0200; if_m.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(if_m.out_valid), 32'd1);
            chk("bp_hold_sum",   32'(if_m.sum),       32'h3333);
            chk("bp_hold_rdy",   32'(if_m.in_ready),  32'd0);
        end
        if_m.out_ready = 1'b1;
        @(posedge clk); #1;
        if_m.out_ready = 1'b0;
        chk("bp_release_rdy", 32'(if_m.in_ready), 32'd1);
        @(posedge clk); #1;
        if_m.in_valid = 1'b0;
        chk("bp_accepted", 32'(if_m.in_ready), 32'd0);
        wait_main(lat);
        chk("bp2_lat", 32'(lat),      32'd4);
        chk("bp2_sum", 32'(if_m.sum), 32'h0300);
        pop_main("bp2");

        // Asynchronous reset two digits into a run.
        if_m.a = 16'h1234; if_m.b = 16'h1111; if_m.in_valid = 1'b1;
        @(posedge clk); #1;
        if_m.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(if_m.out_valid), 32'd0);
        chk("abort_in_ready",  32'(if_m.in_ready),  32'd1);
        chk("abort_sum",       32'(if_m.sum),       32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_no_emit", 32'(if_m.out_valid), 32'd0);
        end
        txn_main("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // DIGIT=1 and DIGIT=16 against a reference built from integer arithmetic.
        for (int v = 0; v < 8; v++) begin
            if (v == 0) begin
                sw_a = 16'h7FFF; sw_b = 16'h0001; sw_cin = 1'b0; sw_sub = 1'b0;
            end else if (v == 1) begin
                sw_a = 16'h8000; sw_b = 16'h0001; sw_cin = 1'b0; sw_sub = 1'b1;
            end else begin
                sw_a = 16'($urandom); sw_b = 16'($urandom);
                sw_cin = 1'($urandom); sw_sub = 1'($urandom);
            end
            sa = {{16{sw_a[15]}}, sw_a};
            sb = {{16{sw_b[15]}}, sw_b};
            ua = {16'd0, sw_a};
            ub = {16'd0, sw_b};
            if (sw_sub) begin
                ru = ua - ub - int'(sw_cin);
                rs = sa - sb - int'(sw_cin);
                e_cout = (ru >= 0);
            end else begin
                ru = ua + ub + int'(sw_cin);
                rs = sa + sb + int'(sw_cin);
                e_cout = (ru > 65535);
            end
            ru_bits = ru;
            e_sum = ru_bits[15:0];
            e_ovf = (rs > 32767) || (rs < -32768);

            chk("sw_d1_rdy",  32'(if_d1.in_ready),  32'd1);
            chk("sw_d16_rdy", 32'(if_d16.in_ready), 32'd1);
            sw_in_valid = 1'b1;
            @(posedge clk); #1;
            sw_in_valid = 1'b0;
            chk("sw_d16_no_early", 32'(if_d16.out_valid), 32'd0);
            lat1 = 0; lat16 = 0;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk); #1;
                if (lat16 == 0 && if_d16.out_valid) lat16 = i;
                if (lat1 == 0 && if_d1.out_valid) lat1 = i;
                if (lat1 != 0 && lat16 != 0) break;
            end
            chk("sw_d1_lat",   32'(lat1),          32'd16);
            chk("sw_d16_lat",  32'(lat16),         32'd1);
            chk("sw_d1_sum",   32'(if_d1.sum),     32'(e_sum));
            chk("sw_d1_cout",  32'(if_d1.cout),    32'(e_cout));
            chk("sw_d1_ovf",   32'(if_d1.ovf),     32'(e_ovf));
            chk("sw_d16_sum",  32'(if_d16.sum),    32'(e_sum));
            chk("sw_d16_cout", 32'(if_d16.cout),   32'(e_cout));
            chk("sw_d16_ovf",  32'(if_d16.ovf),    32'(e_ovf));
            sw_out_ready = 1'b1;
            @(posedge clk); #1;
            sw_out_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
